// File: rtl/fixed_to_float_pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fixed_to_float_pipe_pkg
// Purpose  : Shared types and format helpers for the fixed-to-float pipeline.
//            Holds the rounding-mode enum, the IEEE-754 field-width and bias
//            helpers, and the payload struct carried between pipeline stages.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package fixed_to_float_pipe_pkg;

    typedef enum logic [1:0] {
        RNE = 2'b00,   // round to nearest, ties to even
        RTZ = 2'b01,   // round toward zero
        RUP = 2'b10,   // round toward +infinity
        RDN = 2'b11    // round toward -infinity
    } round_mode_e;

    // Widest mantissa (double) and an exponent wide enough for the unbiased
    // range -DATA_WIDTH-1 .. DATA_WIDTH-1 with DATA_WIDTH up to 64.
    localparam int c_max_mant_w = 52;
    localparam int c_exp_reg_w  = 8;

    function automatic int exp_w(input int precision);
        return (precision == 64) ? 11 : 8;
    endfunction

    function automatic int mant_w(input int precision);
        return (precision == 64) ? 52 : 23;
    endfunction

    function automatic int bias(input int precision);
        return (precision == 64) ? 1023 : 127;
    endfunction

    // Mantissa is right-aligned in the field; upper bits stay zero for single.
    typedef struct packed {
        logic                            sign;
        logic                            zero;
        round_mode_e                     rmode;
        logic signed [c_exp_reg_w-1:0]   exp;
        logic [c_max_mant_w-1:0]         mant;
        logic                            guard;
        logic                            sticky;
    } stage_t;

endpackage
`default_nettype wire

// File: rtl/fixed_to_float_pipe_if.sv
`default_nettype none
// ============================================================================
// Module   : fixed_to_float_pipe_if
// Purpose  : Operand-in / result-out handshake bundle of the converter.
// Ports    : in_valid/in_ready       operand handshake
//            op_sign, op_int,        signed-magnitude operand fields
//            op_fract, round_mode    and rounding mode (00 RNE .. 11 RDN)
//            out_valid/out_ready     result handshake
//            result, is_zero,        IEEE-754 encoding and flags
//            inexact
//            modport slave  : the converter
//            modport master : the operand source / result sink
// Revision : 1.0 - initial release
// ============================================================================
interface fixed_to_float_pipe_if #(
    parameter int DATA_WIDTH = 32,
    parameter int PRECISION  = 32
);
    logic                   in_valid;
    logic                   in_ready;
    logic                   op_sign;
    logic [DATA_WIDTH-1:0]  op_int;
    logic [DATA_WIDTH-1:0]  op_fract;
    logic [1:0]             round_mode;
    logic                   out_valid;
    logic                   out_ready;
    logic [PRECISION-1:0]   result;
    logic                   is_zero;
    logic                   inexact;

    modport master (
        output in_valid, op_sign, op_int, op_fract, round_mode, out_ready,
        input  in_ready, out_valid, result, is_zero, inexact
    );

    modport slave (
        input  in_valid, op_sign, op_int, op_fract, round_mode, out_ready,
        output in_ready, out_valid, result, is_zero, inexact
    );
endinterface
`default_nettype wire

// File: rtl/fixed_to_float_pipe_lzc.sv
`default_nettype none
// ============================================================================
// Module   : leading_zero_counter
// Purpose  : Combinational binary-tree leading-zero counter.
// Ports    : data      in  WIDTH   vector to scan (MSB first)
//            count     out CNT_W   number of leading zeros (WIDTH if all zero)
//            all_zero  out 1       data == 0
// Revision : 1.0 - initial release
// ============================================================================
module leading_zero_counter #(
    parameter  int WIDTH = 64,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic [WIDTH-1:0] data,
    output logic [CNT_W-1:0] count,
    output logic             all_zero
);
    localparam int c_lvls = $clog2(WIDTH);
    localparam int c_p2   = 1 << c_lvls;

    logic [c_p2-1:0]   w_padded;
    logic              w_any;
    logic [c_lvls-1:0] w_cnt;

    // Pad at the LSB end so the leading-zero count of the real bits is unchanged.
    generate
        if (c_p2 == WIDTH) begin : g_exact
            assign w_padded = data;
        end else begin : g_pad
            assign w_padded = {data, {(c_p2 - WIDTH){1'b0}}};
        end
    endgenerate

    // Node i at level k covers 2^k bits (index 0 = most significant). A node
    // whose left half is empty counts that whole half (bit k-1) plus the right
    // child's count.
    function automatic logic [c_lvls:0] lzc_tree(input logic [c_p2-1:0] x);
        logic              any [0:c_lvls][0:c_p2-1];
        logic [c_lvls-1:0] cnt [0:c_lvls][0:c_p2-1];
        for (int k = 0; k <= c_lvls; k++) begin
            for (int i = 0; i < c_p2; i++) begin
                any[k][i] = 1'b0;
                cnt[k][i] = '0;
            end
        end
        for (int i = 0; i < c_p2; i++) begin
            any[0][i] = x[c_p2-1-i];
        end
        for (int k = 1; k <= c_lvls; k++) begin
            for (int i = 0; i < (c_p2 >> k); i++) begin
                any[k][i] = any[k-1][2*i] | any[k-1][2*i+1];
                if (any[k-1][2*i]) begin
                    cnt[k][i] = cnt[k-1][2*i];
                end else begin
                    cnt[k][i]      = cnt[k-1][2*i+1];
                    cnt[k][i][k-1] = 1'b1;
                end
            end
        end
        return {any[c_lvls][0], cnt[c_lvls][0]};
    endfunction

    assign {w_any, w_cnt} = lzc_tree(w_padded);
    assign all_zero       = !w_any;
    assign count          = all_zero ? CNT_W'(WIDTH) : CNT_W'(w_cnt);

endmodule
`default_nettype wire

// File: rtl/fixed_to_float_pipe.sv
`default_nettype none
// ============================================================================
// Module   : fixed_to_float_pipe
// Purpose  : Pipelined signed-magnitude fixed-point (Int.Fract) to IEEE-754
//            single/double converter with selectable rounding, zero and
//            inexact flags. One operand per cycle when not back-pressured.
//            Stages: S1 capture + leading-zero count, S2 normalise,
//            S3 round + pack. LZC_STAGE_SPLIT=0 merges S1 into S2.
// Ports    : clk  in  1   rising-edge clock
//            rst  in  1   synchronous active-high reset
//            bus  slave   operand/result handshake bundle
// Revision : 1.0 - initial release
// ============================================================================
module fixed_to_float_pipe
    import fixed_to_float_pipe_pkg::*;
#(
    parameter int DATA_WIDTH      = 32,
    parameter int PRECISION       = 32,
    parameter int LZC_STAGE_SPLIT = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    fixed_to_float_pipe_if.slave bus
);
    localparam int c_m_w    = 2 * DATA_WIDTH;
    localparam int c_cnt_w  = $clog2(c_m_w + 1);
    localparam int c_mant_w = mant_w(PRECISION);
    localparam int c_exp_w  = exp_w(PRECISION);
    localparam int c_bias   = bias(PRECISION);
    // Normalised magnitude with enough zero padding below it that short
    // operands still yield a full mantissa plus guard bit.
    localparam int c_ext_w  = c_m_w + c_mant_w + 2;

    // ------------------------------------------------------------------
    // Shared stall: the whole pipe freezes while the output is held.
    // ------------------------------------------------------------------
    logic w_stall;
    logic w_en;
    logic w_accept;
    logic r_s3_valid;

    assign w_stall      = r_s3_valid && !bus.out_ready;
    assign w_en         = !w_stall;
    assign w_accept     = bus.in_valid && w_en;
    assign bus.in_ready = w_en;

    // ------------------------------------------------------------------
    // S1: capture + leading-zero count
    // ------------------------------------------------------------------
    logic [c_m_w-1:0]   w_in_m;
    logic [c_cnt_w-1:0] w_in_lzc;
    logic               w_in_zero;
    round_mode_e        w_in_rmode;

    assign w_in_m     = {bus.op_int, bus.op_fract};
    assign w_in_rmode = round_mode_e'(bus.round_mode);

    leading_zero_counter #(
        .WIDTH (c_m_w)
    ) u_lzc (
        .data     (w_in_m),
        .count    (w_in_lzc),
        .all_zero (w_in_zero)
    );

    logic               w_s1_valid;
    logic [c_m_w-1:0]   w_s1_m;
    logic [c_cnt_w-1:0] w_s1_lzc;
    logic               w_s1_zero;
    logic               w_s1_sign;
    round_mode_e        w_s1_rmode;

    generate
        if (LZC_STAGE_SPLIT != 0) begin : g_split
            logic               r_valid;
            logic [c_m_w-1:0]   r_m;
            logic [c_cnt_w-1:0] r_lzc;
            logic               r_zero;
            logic               r_sign;
            round_mode_e        r_rmode;

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_valid <= 1'b0;
                    r_m     <= '0;
                    r_lzc   <= '0;
                    r_zero  <= 1'b0;
                    r_sign  <= 1'b0;
                    r_rmode <= RNE;
                end else if (w_en) begin
                    r_valid <= w_accept;
                    r_m     <= w_in_m;
                    r_lzc   <= w_in_lzc;
                    r_zero  <= w_in_zero;
                    r_sign  <= bus.op_sign;
                    r_rmode <= w_in_rmode;
                end
            end

            assign w_s1_valid = r_valid;
            assign w_s1_m     = r_m;
            assign w_s1_lzc   = r_lzc;
            assign w_s1_zero  = r_zero;
            assign w_s1_sign  = r_sign;
            assign w_s1_rmode = r_rmode;
        end else begin : g_merge
            assign w_s1_valid = w_accept;
            assign w_s1_m     = w_in_m;
            assign w_s1_lzc   = w_in_lzc;
            assign w_s1_zero  = w_in_zero;
            assign w_s1_sign  = bus.op_sign;
            assign w_s1_rmode = w_in_rmode;
        end
    endgenerate

    // ------------------------------------------------------------------
    // S2: normalise. Shifting by L+1 drops the hidden one off the top.
    // ------------------------------------------------------------------
    logic [c_m_w-1:0]   w_shifted;
    logic [c_ext_w-1:0] w_ext;
    stage_t             w_s2_next;
    stage_t             r_s2;
    logic               r_s2_valid;

    always_comb begin
        w_shifted        = w_s1_m << (w_s1_lzc + 1);
        w_ext            = {w_shifted, {(c_mant_w + 2){1'b0}}};
        w_s2_next        = '0;
        w_s2_next.sign   = w_s1_sign;
        w_s2_next.zero   = w_s1_zero;
        w_s2_next.rmode  = w_s1_rmode;
        // Leading one sits at bit (c_m_w-1-L); the binary point is at DATA_WIDTH.
        w_s2_next.exp    = c_exp_reg_w'(DATA_WIDTH - 1 - int'(w_s1_lzc));
        w_s2_next.mant   = c_max_mant_w'(w_ext[c_ext_w-1 -: c_mant_w]);
        w_s2_next.guard  = w_ext[c_ext_w-1-c_mant_w];
        w_s2_next.sticky = |w_ext[c_ext_w-2-c_mant_w:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s2_valid <= 1'b0;
            r_s2       <= '0;
        end else if (w_en) begin
            r_s2_valid <= w_s1_valid;
            r_s2       <= w_s2_next;
        end
    end

    // ------------------------------------------------------------------
    // S3: round + pack
    // ------------------------------------------------------------------
    logic                  w_inc;
    logic [c_max_mant_w:0] w_sum;
    logic                  w_carry;
    logic [c_mant_w-1:0]   w_mant_out;
    logic [c_exp_w-1:0]    w_exp_field;
    logic [PRECISION-1:0]  w_result;
    logic                  w_inexact;

    always_comb begin
        w_inc = 1'b0;
        case (r_s2.rmode)
            RNE:     w_inc = r_s2.guard && (r_s2.sticky || r_s2.mant[0]);
            RTZ:     w_inc = 1'b0;
            RUP:     w_inc = !r_s2.sign && (r_s2.guard || r_s2.sticky);
            RDN:     w_inc = r_s2.sign && (r_s2.guard || r_s2.sticky);
            default: w_inc = 1'b0;
        endcase
    end

    // Anything reaching bit c_mant_w or above is the rounding carry-out; the
    // remaining mantissa bits are then all zero, which is the wrapped value.
    assign w_sum       = {1'b0, r_s2.mant} + {{c_max_mant_w{1'b0}}, w_inc};
    assign w_carry     = |w_sum[c_max_mant_w:c_mant_w];
    assign w_mant_out  = w_sum[c_mant_w-1:0];
    assign w_exp_field = c_exp_w'(int'($signed(r_s2.exp)) + c_bias + (w_carry ? 1 : 0));
    assign w_result    = r_s2.zero ? {r_s2.sign, {(PRECISION - 1){1'b0}}}
                                   : {r_s2.sign, w_exp_field, w_mant_out};
    assign w_inexact   = !r_s2.zero && (r_s2.guard || r_s2.sticky);

    logic [PRECISION-1:0] r_s3_result;
    logic                 r_s3_zero;
    logic                 r_s3_inexact;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s3_valid   <= 1'b0;
            r_s3_result  <= '0;
            r_s3_zero    <= 1'b0;
            r_s3_inexact <= 1'b0;
        end else if (w_en) begin
            r_s3_valid   <= r_s2_valid;
            r_s3_result  <= w_result;
            r_s3_zero    <= r_s2.zero;
            r_s3_inexact <= w_inexact;
        end
    end

    assign bus.out_valid = r_s3_valid;
    assign bus.result    = r_s3_result;
    assign bus.is_zero   = r_s3_zero;
    assign bus.inexact   = r_s3_inexact;

endmodule
`default_nettype wire
